register_bank_mp: RTL and testbench

//  Parametrised successor of the pipeline register bank for the MIPS core: DEPTH x WIDTH

---
 rtl/register_bank_mp.sv | 119 +++++++++++
 tb/tb_register_bank_mp.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/register_bank_mp.sv
// register_bank_mp: DEPTH x WIDTH register bank for the MIPS ID stage.
// NUM_RD registered read ports, one write port, one combinational debug read port.
// After reset, a sequential clear sweep zeroes one entry per cycle while busy is high.
// Optional feature: define REGBANK_BYPASS_EN for write-first forwarding on the read ports;
// left undefined, a same-edge read of the written entry returns the old stored value.
module register_bank_mp #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*WIDTH-1:0]    rd_data,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [ADDR_W-1:0]          dbg_addr,
  output logic [WIDTH-1:0]           dbg_data,
  output logic                       busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t                    state_p0, state_nxt;
  logic [ADDR_W-1:0]         clr_ptr_p0, clr_ptr_nxt;
  logic [WIDTH-1:0]          mem [DEPTH];
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_waddr;
  logic [WIDTH-1:0]          mem_wdata;
  logic                      wr_keep;
  logic [ADDR_W-1:0]         ra;
  logic [WIDTH-1:0]          word;
  logic [NUM_RD*WIDTH-1:0]   rd_nxt;
  logic [NUM_RD*WIDTH-1:0]   rd_data_p1;

  // Entry 0 is hard-wired to zero when the bank models MIPS $zero.
  function automatic logic is_zero_entry(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Control state: reset parks the sweep at entry 0; otherwise follow next-state logic.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p0   <= CLEAR;
      clr_ptr_p0 <= '0;
    end else begin
      state_p0   <= state_nxt;
      clr_ptr_p0 <= clr_ptr_nxt;
    end
  end

  // Next state and the single shared write port (sweep zeroes or user write).
  always_comb begin
    state_nxt   = state_p0;
    clr_ptr_nxt = clr_ptr_p0;
    wr_keep     = wr_en && !is_zero_entry(wr_addr);
    mem_we      = 1'b0;
    mem_waddr   = wr_addr;
    mem_wdata   = wr_data;
    case (state_p0)
      CLEAR: begin
        mem_we      = 1'b1;
        mem_waddr   = clr_ptr_p0;
        mem_wdata   = '0;
        clr_ptr_nxt = clr_ptr_p0 + 1'b1;
        if (clr_ptr_p0 == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN: begin
        mem_we = wr_keep;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Storage: one write per cycle, no reset on the array so it maps onto RAM.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

  // Read-port lookup ahead of the output register, with zero entry and optional forwarding.
  always_comb begin
    rd_nxt = '0;
    ra     = '0;
    word   = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra   = rd_addr[k*ADDR_W +: ADDR_W];
      word = mem[ra];
`ifdef REGBANK_BYPASS_EN
      if (wr_keep && (ra == wr_addr)) word = wr_data;
`endif
      if (is_zero_entry(ra)) word = '0;
      rd_nxt[k*WIDTH +: WIDTH] = word;
    end
  end

  // ---- stage p1: registered read data, forced to zero until the sweep finishes ----
  // Output register: cleared by reset and during the sweep, held while stalled.
  always_ff @(posedge clock) begin
    if (reset || (state_p0 == CLEAR)) begin
      rd_data_p1 <= '0;
    end else if (!stall) begin
      rd_data_p1 <= rd_nxt;
    end
  end

  assign rd_data = rd_data_p1;
  assign busy    = (state_p0 == CLEAR);

  // Debug port reads storage directly; never forwarded.
  always_comb begin
    dbg_data = is_zero_entry(dbg_addr) ? '0 : mem[dbg_addr];
  end

endmodule

// File: tb/tb_register_bank_mp.sv
// tb_register_bank_mp: randomized and directed stimulus for register_bank_mp, built
// twice (ZERO_REG=1 and ZERO_REG=0) on shared inputs; an array-based reference model
// predicts each cycle's outputs into a queue and a monitor compares after every edge.
module tb_register_bank_mp;

  localparam int W     = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic              clock = 1'b0;
  logic              reset, stall, wr_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [AW-1:0]     wr_addr, dbg_addr;
  logic [W-1:0]      wr_data;
  logic [NR*W-1:0]   rd_data_z1, rd_data_z0;
  logic [W-1:0]      dbg_data_z1, dbg_data_z0;
  logic              busy_z1, busy_z0;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  register_bank_mp #(.WIDTH(W), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) u_z1 (
    .clock(clock), .reset(reset), .stall(stall), .rd_addr(rd_addr), .rd_data(rd_data_z1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data_z1), .busy(busy_z1));

  register_bank_mp #(.WIDTH(W), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) u_z0 (
    .clock(clock), .reset(reset), .stall(stall), .rd_addr(rd_addr), .rd_data(rd_data_z0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data_z0), .busy(busy_z0));

  typedef struct {
    logic [NR*W-1:0] rd1;
    logic [NR*W-1:0] rd0;
    logic            bsy;
    logic            dbg_chk;
    logic [W-1:0]    dbg1;
    logic [W-1:0]    dbg0;
  } exp_t;

  exp_t q[$];

  // Reference model: plain arrays and a count of sweep cycles still owed.
  logic [W-1:0]    m1 [DEPTH];
  logic [W-1:0]    m0 [DEPTH];
  logic [NR*W-1:0] r1 = '0;
  logic [NR*W-1:0] r0 = '0;
  int              sweep_left = 0;
  logic            bypass;

  initial begin
`ifdef REGBANK_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endfunction

  // One clock cycle of stimulus plus its predicted post-edge outputs.
  task automatic step(input logic rst, input logic stl, input logic we, input logic [AW-1:0] wa,
                      input logic [W-1:0] wd, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                      input logic [AW-1:0] da);
    exp_t e;
    logic [AW-1:0] ra;
    @(negedge clock);
    reset = rst; stall = stl; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr = {ra1, ra0}; dbg_addr = da;
    if (rst) begin
      sweep_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin m1[i] = '0; m0[i] = '0; end
      r1 = '0; r0 = '0;
    end else if (sweep_left > 0) begin
      sweep_left--;
      r1 = '0; r0 = '0;
    end else begin
      if (!stl) begin
        for (int k = 0; k < NR; k++) begin
          ra = (k == 0) ? ra0 : ra1;
          r0[k*W +: W] = (bypass && we && ra == wa) ? wd : m0[ra];
          if (ra == 0) r1[k*W +: W] = '0;
          else r1[k*W +: W] = (bypass && we && ra == wa) ? wd : m1[ra];
        end
      end
      if (we) begin
        m0[wa] = wd;
        if (wa != 0) m1[wa] = wd;
      end
    end
    e.rd1 = r1; e.rd0 = r0;
    e.bsy = (sweep_left > 0);
    e.dbg_chk = (sweep_left == 0);
    e.dbg1 = (da == 0) ? '0 : m1[da];
    e.dbg0 = m0[da];
    q.push_back(e);
  endtask

  task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, ra0, ra1, ra0);
  endtask

  task automatic rand_step(input logic rst_allowed, input int amax);
    step(rst_allowed && ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
         $urandom_range(0, 1) == 1, AW'($urandom_range(0, amax)), $urandom,
         AW'($urandom_range(0, amax)), AW'($urandom_range(0, amax)), AW'($urandom_range(0, amax)));
  endtask

  // Monitor: after every rising edge, pop the prediction and compare both builds.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("rd_data_z1", 64'(rd_data_z1), 64'(e.rd1));
        check("rd_data_z0", 64'(rd_data_z0), 64'(e.rd0));
        check("busy_z1", 64'(busy_z1), 64'(e.bsy));
        check("busy_z0", 64'(busy_z0), 64'(e.bsy));
        if (e.dbg_chk) begin
          check("dbg_data_z1", 64'(dbg_data_z1), 64'(e.dbg1));
          check("dbg_data_z0", 64'(dbg_data_z0), 64'(e.dbg0));
        end
      end
    end
  end

  initial begin
    int waited;
    reset = 1'b0; stall = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; dbg_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin m1[i] = '0; m0[i] = '0; end

    // Reset one cycle, then the sweep with write attempts that must be ignored.
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < DEPTH; i++) rand_step(1'b0, DEPTH - 1);
    for (int a = 0; a < DEPTH; a++) idle(AW'(a), AW'(DEPTH - 1 - a));

    // Write then read back through port 0.
    step(1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 5'd5);
    idle(5'd5, 5'd5);

    // Entry 0 write: dropped in the ZERO_REG=1 build only.
    step(1'b0, 1'b0, 1'b1, 5'd0, 32'h12345678, 5'd3, 5'd3, 5'd0);
    idle(5'd0, 5'd0);

    // Stall holds read data while the write still lands.
    idle(5'd7, 5'd5);
    step(1'b0, 1'b1, 1'b1, 5'd7, 32'hAAAA5555, 5'd7, 5'd7, 5'd7);
    step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7);
    idle(5'd7, 5'd7);

    // Same-edge write and read of entry 9, and of entry 0.
    step(1'b0, 1'b0, 1'b1, 5'd9, 32'h11112222, 5'd1, 5'd2, 5'd9);
    step(1'b0, 1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd9, 5'd9);
    step(1'b0, 1'b0, 1'b1, 5'd0, 32'h0BADF00D, 5'd0, 5'd9, 5'd0);
    idle(5'd9, 5'd0);

    // Random traffic over a narrow address range to force collisions.
    for (int i = 0; i < 300; i++) rand_step(1'b0, 7);
    for (int i = 0; i < 200; i++) rand_step(1'b0, DEPTH - 1);

    // Reset mid-sweep at entry 10: sweep restarts from 0, writes ignored throughout.
    step(1'b1, 1'b0, 1'b1, 5'd4, 32'h55555555, 5'd4, 5'd4, 5'd4);
    for (int i = 0; i < 10; i++) rand_step(1'b0, DEPTH - 1);
    step(1'b1, 1'b0, 1'b1, 5'd10, 32'h77777777, 5'd10, 5'd10, 5'd10);
    for (int i = 0; i < DEPTH; i++) rand_step(1'b0, DEPTH - 1);
    for (int a = 0; a < DEPTH; a++) idle(AW'(a), AW'(a));

    // More random traffic, occasionally with reset pulses.
    for (int i = 0; i < 400; i++) rand_step(1'b1, DEPTH - 1);
    for (int i = 0; i < DEPTH + 2; i++) idle(5'd1, 5'd2);

    waited = 0;
    while (q.size() != 0 && waited < 10) begin
      @(posedge clock);
      waited++;
    end
    #2;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
